md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//  Multiply/divide responder in the E stage: consumes start/md_op/operands issued by the
//  D->E pipeline register and owns the HI/LO registers. Holds busy for a fixed
//  multi-cycle latency and drives md_stall back to the hazard logic, which freezes the
//  D->E register while an MD-dependent instruction waits in D.
// PARAMETERS
//  MULT_CYCLES  5   busy duration for MULT/MULTU (and MADD/MSUB); legal range >= 1
//  DIV_CYCLES   10  busy duration for DIV/DIVU; legal range >= 1
// PORTS
//  clk        in   1   clock, all state on posedge
//  reset      in   1   synchronous, active-high
//  start      in   1   E-stage startMD; qualifies md_op this cycle
//  md_op      in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB
//  a          in   32  rs operand (forwarded)
//  b          in   32  rt operand (forwarded)
//  md_use_d   in   1   D-stage instruction is MULT/DIV/MF*/MT* class
//  busy       out  1   operation in flight
//  md_stall   out  1   = md_use_d & (start | busy), combinational
//  hi         out  32  HI register
//  lo         out  32  LO register
// BEHAVIOUR
//  - Reset: busy=0, hi=0, lo=0, internal counter=0, latched operands/op cleared.
//    Reset mid-operation aborts it; result is discarded and never written.
//  - Accept: posedge with start=1 & busy=0. Ops 0-3 (and 6-7 if enabled): latch a, b, op;
//    counter<=N (MULT_CYCLES or DIV_CYCLES); busy<=1 next cycle.
//  - Countdown: each posedge with busy=1 decrements counter; at the posedge where counter==1,
//    busy<=0 and {hi,lo}<=result. busy is high exactly N cycles; new hi/lo are visible in
//    the first cycle busy is low. Latency accept-edge to hi/lo-valid = N cycles.
//  - MTHI/MTLO: accepted with start=1 & busy=0; hi<=a (or lo<=a) at that edge, busy stays 0.
//  - start=1 while busy=1: ignored entirely (no latch, no HI/LO write); hazard logic must
//    prevent it, bench flags it as a warning.
//  - MULT: {hi,lo} = signed 32x32 -> 64. MULTU: unsigned 64-bit product.
//  - DIV: signed, quotient truncates toward zero -> lo; remainder (sign of dividend) -> hi.
//    DIVU: unsigned lo=a/b, hi=a%b.
//  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
//  - Divide by zero (DIV/DIVU, b=0): full busy duration, hi/lo left unchanged.
//  - Result computed from latched operands, never from live a/b during busy.
//  - md_stall has no registered delay; it is asserted in the accept cycle (start=1) too.
// CONFIGURATION
//  MD_MADD_EN defined: op 6 MADD {hi,lo} <= {hi,lo} + signed(a*b); op 7 MSUB
//    {hi,lo} <= {hi,lo} - signed(a*b); both use MULT_CYCLES, accumulate base sampled at
//    writeback edge (64-bit, wrap-around modulo 2^64).
//  MD_MADD_EN undefined: ops 6/7 are no-ops: not accepted, busy stays 0, hi/lo unchanged.
// STRUCTURE
//  - md_pkg: md_op encodings (MD_MULT..MD_MSUB), default cycle counts, counter width
//    derived as $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
//  - Single module; no sub-module needed. Result path is combinational on latched operands,
//    registered into hi/lo only at the final busy cycle.
// TESTING
//  - MULT a=0xFFFFFFFE(-2), b=3 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF,
//    lo=0xFFFFFFFA; MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
//  - DIV a=-7, b=2 -> busy 10 cycles, lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1);
//    DIVU a=7, b=2 -> lo=3, hi=1.
//  - MTHI a=0x12345678 then MTLO a=0x9ABCDEF0 back-to-back -> hi/lo updated at each
//    edge, busy never asserted.
//  - DIV b=0 with hi=0xAAAA0000, lo=0x5555 preset -> busy 10 cycles, hi/lo unchanged;
//    DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//  - MULT accepted, reset asserted at busy cycle 3 -> busy=0, hi=lo=0 next cycle, no
//    later write; start during busy -> ignored, original result written on time.
//  - md_use_d=1 with start=1 -> md_stall=1 same cycle, held through busy, drops with busy;
//    MD_MADD_EN: hi:lo=0:10, MADD 3*4 -> lo=22; MSUB 3*4 from 0:0 -> hi=lo=0xFFFFFFFF/0xFFFFFFF4.

Source files
------------

// File: rtl/md_pkg.sv
// md_pkg
//  Shared definitions for the multiply/divide unit: md_op encodings, default
//  busy durations and the helper that sizes the countdown register.
//  Optional feature macro referenced by users of this package: MD_MADD_EN.
package md_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_MADD  = 3'd6,
        MD_MSUB  = 3'd7
    } md_op_e;

    localparam int MD_DEF_MULT_CYCLES = 5;
    localparam int MD_DEF_DIV_CYCLES  = 10;

    // Counter must hold the larger of the two busy durations.
    function automatic int md_cnt_w(input int mult_cycles, input int div_cycles);
        int mx;
        mx = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
        return $clog2(mx + 1);
    endfunction

endpackage

// File: rtl/md_unit.sv
// md_unit
//  E-stage multiply/divide responder. Owns HI/LO, holds busy for a fixed
//  latency per operation class and reports md_stall to the hazard logic.
//  Optional feature: define MD_MADD_EN to enable MADD (op 6) / MSUB (op 7);
//  otherwise those encodings are ignored.
// Ports
//  clk       in   clock, posedge
//  reset     in   synchronous, active-high
//  start     in   qualifies md_op this cycle
//  md_op     in   [2:0] operation (see md_pkg::md_op_e)
//  a, b      in   [31:0] rs / rt operands
//  md_use_d  in   D-stage instruction depends on the MD unit
//  busy      out  operation in flight
//  md_stall  out  md_use_d & (start | busy), combinational
//  hi, lo    out  [31:0] HI / LO registers
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use_d,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CW = md_cnt_w(MULT_CYCLES, DIV_CYCLES);

    md_op_e      op_in;
    md_op_e      op_q;
    logic [CW-1:0] cnt;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        long_op;
    logic        mult_class;

    assign op_in    = md_op_e'(md_op);
    assign md_stall = md_use_d & (start | busy);

    always_comb begin
        mult_class = 1'b0;
        long_op    = 1'b0;
        case (op_in)
            MD_MULT, MD_MULTU: begin
                mult_class = 1'b1;
                long_op    = 1'b1;
            end
            MD_DIV, MD_DIVU: long_op = 1'b1;
`ifdef MD_MADD_EN
            MD_MADD, MD_MSUB: begin
                mult_class = 1'b1;
                long_op    = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Result datapath, purely from the latched operands.
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000
    // without relying on signed-overflow behaviour of the division operator.
    logic [31:0] mag_a, mag_b, div_b_s, div_b_u;
    logic [31:0] uq, ur, sq, sr;
    assign mag_a   = a_q[31] ? (32'd0 - a_q) : a_q;
    assign mag_b   = b_q[31] ? (32'd0 - b_q) : b_q;
    assign div_b_s = (b_q == 32'd0) ? 32'd1 : mag_b;
    assign div_b_u = (b_q == 32'd0) ? 32'd1 : b_q;
    assign uq      = mag_a / div_b_s;
    assign ur      = mag_a % div_b_s;
    assign sq      = (a_q[31] ^ b_q[31]) ? (32'd0 - uq) : uq;
    assign sr      = a_q[31] ? (32'd0 - ur) : ur;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            cnt  <= '0;
            op_q <= MD_MULT;
            a_q  <= '0;
            b_q  <= '0;
            hi   <= '0;
            lo   <= '0;
        end else if (busy) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                busy <= 1'b0;
                case (op_q)
                    MD_MULT:  {hi, lo} <= prod_s;
                    MD_MULTU: {hi, lo} <= prod_u;
                    MD_DIV: if (b_q != 32'd0) begin
                        lo <= sq;
                        hi <= sr;
                    end
                    MD_DIVU: if (b_q != 32'd0) begin
                        lo <= a_q / div_b_u;
                        hi <= a_q % div_b_u;
                    end
`ifdef MD_MADD_EN
                    MD_MADD: {hi, lo} <= {hi, lo} + prod_s;
                    MD_MSUB: {hi, lo} <= {hi, lo} - prod_s;
`endif
                    default: ;
                endcase
            end
        end else if (start) begin
            if (long_op) begin
                op_q <= op_in;
                a_q  <= a;
                b_q  <= b;
                busy <= 1'b1;
                cnt  <= mult_class ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            end else if (op_in == MD_MTHI) begin
                hi <= a;
            end else if (op_in == MD_MTLO) begin
                lo <= a;
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
    import md_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_use_d;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    md_unit dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op), .a(a), .b(b),
        .md_use_d(md_use_d), .busy(busy), .md_stall(md_stall), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] av;
        logic [31:0] bv;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          cyc;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        start = 1'b1;
        md_op = op;
        a     = av;
        b     = bv;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic preset(input logic [31:0] h, input logic [31:0] l);
        issue(MD_MTHI, h, 32'd0);
        issue(MD_MTLO, l, 32'd0);
    endtask

    // Reference model: plain integer arithmetic on the specification's rules.
    function automatic int model_cycles(input logic [2:0] op);
        if (op <= 3'd1) return 5;
        if (op <= 3'd3) return 10;
        return 0;
    endfunction

    function automatic logic [63:0] model_result(input logic [2:0] op, input logic [31:0] av,
                                                 input logic [31:0] bv, input logic [63:0] old);
        int sa, sb;
        longint sp, sq, sr;
        longint unsigned ua, ub;
        logic [63:0] r;
        sa = av;
        sb = bv;
        ua = av;
        ub = bv;
        r  = old;
        case (op)
            3'd0: begin sp = longint'(sa) * longint'(sb); r = sp; end
            3'd1: r = ua * ub;
            3'd2: if (bv != 0) begin
                sq = longint'(sa) / longint'(sb);
                sr = longint'(sa) % longint'(sb);
                r  = {sr[31:0], sq[31:0]};
            end
            3'd3: if (bv != 0) r = {32'(ua % ub), 32'(ua / ub)};
            3'd4: r = {av, old[31:0]};
            3'd5: r = {old[63:32], av};
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        int cyc;
        logic [63:0] ref_hl;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        reset = 1'b1; start = 1'b0; md_op = 3'd0; a = '0; b = '0; md_use_d = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        reset = 1'b0;

        vt.push_back('{"mult_neg",   MD_MULT,  32'hFFFFFFFE, 32'd3, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFA, 5});
        vt.push_back('{"multu",      MD_MULTU, 32'hFFFFFFFE, 32'd3, 0, 0, 32'h00000002, 32'hFFFFFFFA, 5});
        vt.push_back('{"div_neg",    MD_DIV,   32'hFFFFFFF9, 32'd2, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10});
        vt.push_back('{"divu",       MD_DIVU,  32'd7, 32'd2, 0, 0, 32'd1, 32'd3, 10});
        vt.push_back('{"div_zero",   MD_DIV,   32'd99, 32'd0, 32'hAAAA0000, 32'h5555, 32'hAAAA0000, 32'h5555, 10});
        vt.push_back('{"divu_zero",  MD_DIVU,  32'd99, 32'd0, 32'h1, 32'h2, 32'h1, 32'h2, 10});
        vt.push_back('{"div_ovf",    MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h7, 32'h7, 32'h0, 32'h80000000, 10});
        vt.push_back('{"mult_min",   MD_MULT,  32'h80000000, 32'h80000000, 0, 0, 32'h40000000, 32'h0, 5});
        vt.push_back('{"multu_max",  MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFE, 32'h1, 5});
        vt.push_back('{"div_negb",   MD_DIV,   32'd7, 32'hFFFFFFFE, 0, 0, 32'd1, 32'hFFFFFFFD, 10});
`ifdef MD_MADD_EN
        vt.push_back('{"madd",       MD_MADD,  32'd3, 32'd4, 32'd0, 32'd10, 32'd0, 32'd22, 5});
        vt.push_back('{"msub",       MD_MSUB,  32'd3, 32'd4, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF4, 5});
`else
        vt.push_back('{"madd_off",   MD_MADD,  32'd3, 32'd4, 32'd0, 32'd10, 32'd0, 32'd10, 0});
        vt.push_back('{"msub_off",   MD_MSUB,  32'd3, 32'd4, 32'd5, 32'd6, 32'd5, 32'd6, 0});
`endif

        foreach (vt[i]) begin
            preset(vt[i].pre_hi, vt[i].pre_lo);
            issue(vt[i].op, vt[i].av, vt[i].bv);
            wait_idle(cyc);
            check({vt[i].name, "_cycles"}, cyc, vt[i].cyc);
            check({vt[i].name, "_hi"}, hi, vt[i].exp_hi);
            check({vt[i].name, "_lo"}, lo, vt[i].exp_lo);
        end

        // MTHI then MTLO back-to-back
        @(negedge clk);
        start = 1'b1; md_op = MD_MTHI; a = 32'h12345678;
        @(negedge clk);
        check("mthi_hi", hi, 32'h12345678);
        check("mthi_busy", busy, 0);
        md_op = MD_MTLO; a = 32'h9ABCDEF0;
        @(negedge clk);
        start = 1'b0;
        check("mtlo_lo", lo, 32'h9ABCDEF0);
        check("mtlo_hi", hi, 32'h12345678);
        check("mtlo_busy", busy, 0);

        // Reset in busy cycle 3 aborts the operation
        issue(MD_MULT, 32'd3, 32'd5);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        repeat (8) @(negedge clk);
        check("abort_nowrite", {hi, lo}, 64'd0);

        // start while busy is ignored
        issue(MD_MULT, 32'hFFFFFFFE, 32'd3);
        @(negedge clk);
        $display("warning: start issued while busy (expected to be ignored)");
        start = 1'b1; md_op = MD_MTHI; a = 32'hDEAD0000;
        @(negedge clk);
        md_op = MD_DIV; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        cyc = 3;
        while (busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        check("ignore_cycles", cyc, 5);
        check("ignore_hi", hi, 32'hFFFFFFFF);
        check("ignore_lo", lo, 32'hFFFFFFFA);

        // md_stall behaviour
        @(negedge clk);
        md_use_d = 1'b1; start = 1'b1; md_op = MD_MULT; a = 32'd2; b = 32'd2;
        #1 check("stall_accept", md_stall, 1);
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 100) begin
            if (!md_stall) check("stall_busy", md_stall, 1);
            cyc++;
            @(negedge clk);
        end
        check("stall_cycles", cyc, 5);
        check("stall_drop", md_stall, 0);
        md_use_d = 1'b0;
        issue(MD_DIV, 32'd9, 32'd3);
        check("stall_nouse", md_stall, 0);
        wait_idle(cyc);

        // Randomized ops against the reference model
        ref_hl = {hi, lo};
        for (int k = 0; k < 40; k++) begin
            rop = 3'($urandom_range(0, 5));
            ra  = $urandom;
            rb  = ($urandom_range(0, 6) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 9) == 0) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            issue(rop, ra, rb);
            wait_idle(cyc);
            ref_hl = model_result(rop, ra, rb, ref_hl);
            check("rand_cycles", cyc, model_cycles(rop));
            check("rand_hilo", {hi, lo}, ref_hl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
